// File: rtl/z16_pkg.sv
// Shared definitions for the Z16 data-memory arbiter: FSM states and port indices.
package z16_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam int unsigned PORT_CPU = 0;
  localparam int unsigned PORT_DMA = 1;

endpackage

// File: rtl/z16_rr_pick.sv
// Two-way round-robin chooser: on a tie the port other than 'last' wins.
module z16_rr_pick
  import z16_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic [1:0] req_m;

  always_comb begin
    req_m = req & mask;
    gnt   = '0;
    if (req_m == 2'b11) begin
      gnt[PORT_CPU] = last;
      gnt[PORT_DMA] = ~last;
    end else begin
      gnt = req_m;
    end
  end

endmodule

// File: rtl/z16_dmem_arbiter.sv
// Shares the single-port Z16 data memory between CPU (port 0) and DMA/debug (port 1)
// with round-robin grants, bounded locked bursts and one-cycle read responses.
module z16_dmem_arbiter
  import z16_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,

  input  logic              i_req0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic              i_wen0,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic              i_lock0,
  output logic              o_gnt0,
  output logic              o_rvalid0,
  output logic [DATA_W-1:0] o_rdata0,

  input  logic              i_req1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic              i_wen1,
  input  logic [DATA_W-1:0] i_wdata1,
  input  logic              i_lock1,
  output logic              o_gnt1,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata1,

  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wen,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  // r_beats + 1 < MAX_BURST  <=>  r_beats < MAX_BURST - 1
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  arb_state_t    r_state, nx_state;
  logic          r_last;
  logic [BW-1:0] r_beats, nx_beats;
  logic [1:0]    r_rd_pend;

  logic [1:0] req, lock, wen, mask, pick_gnt, gnt;
  logic       own;

  assign req  = {i_req1, i_req0};
  assign lock = {i_lock1, i_lock0};
  assign wen  = {i_wen1, i_wen0};
  assign own  = (r_state == LOCK1);

  always_comb begin
    unique case (r_state)
      LOCK0:   mask = 2'b01;
      LOCK1:   mask = 2'b10;
      default: mask = 2'b11;
    endcase
  end

  z16_rr_pick u_pick (
    .req  (req),
    .last (r_last),
    .mask (mask),
    .gnt  (pick_gnt)
  );

  assign gnt = pick_gnt & {2{~i_rst}};

  always_comb begin
    nx_state = r_state;
    nx_beats = r_beats;
    unique case (r_state)
      IDLE: begin
        if (gnt[PORT_CPU] && i_lock0) begin
          nx_state = LOCK0;
          nx_beats = BW'(1);
        end else if (gnt[PORT_DMA] && i_lock1) begin
          nx_state = LOCK1;
          nx_beats = BW'(1);
        end
      end
      LOCK0, LOCK1: begin
        // A missing owner request (bubble) also lands here because gnt[own] is 0.
        if (gnt[own] && lock[own] && (r_beats < LAST_BEAT)) begin
          nx_beats = r_beats + BW'(1);
        end else begin
          nx_state = IDLE;
          nx_beats = '0;
        end
      end
      default: begin
        nx_state = IDLE;
        nx_beats = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_beats   <= '0;
      r_rd_pend <= '0;
    end else begin
      r_state   <= nx_state;
      r_beats   <= nx_beats;
      r_rd_pend <= gnt & ~wen;
      if (|gnt) begin
        r_last <= gnt[PORT_DMA];
      end
    end
  end

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wen   = 1'b0;
    o_mem_wdata = '0;
    if (gnt[PORT_CPU]) begin
      o_mem_addr  = i_addr0;
      o_mem_wen   = i_wen0;
      o_mem_wdata = i_wdata0;
    end else if (gnt[PORT_DMA]) begin
      o_mem_addr  = i_addr1;
      o_mem_wen   = i_wen1;
      o_mem_wdata = i_wdata1;
    end
  end

  assign o_mem_en  = |gnt;
  assign o_gnt0    = gnt[PORT_CPU];
  assign o_gnt1    = gnt[PORT_DMA];
  assign o_rvalid0 = r_rd_pend[PORT_CPU] & ~i_rst;
  assign o_rvalid1 = r_rd_pend[PORT_DMA] & ~i_rst;
  assign o_rdata0  = i_mem_rdata;
  assign o_rdata1  = i_mem_rdata;

endmodule

// File: tb/tb_z16_dmem_arbiter.sv
// Scoreboard bench for z16_dmem_arbiter: queued masters, behavioural memory, expected grant sequences.
module tb_z16_dmem_arbiter;

  typedef struct {
    logic        bubble;
    logic [15:0] addr;
    logic        wen;
    logic [15:0] wdata;
    logic        lock;
  } cmd_t;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req0, i_wen0, i_lock0, i_req1, i_wen1, i_lock1;
  logic [15:0] i_addr0, i_wdata0, i_addr1, i_wdata1;
  logic        o_gnt0, o_rvalid0, o_gnt1, o_rvalid1;
  logic [15:0] o_rdata0, o_rdata1;
  logic        o_mem_en, o_mem_wen;
  logic [15:0] o_mem_addr, o_mem_wdata;
  logic [15:0] i_mem_rdata;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  cmd_t        q0[$], q1[$];
  int          exp_gnt[$];
  logic [15:0] sb0[$], sb1[$];
  logic        exp_rv0 = 1'b0, exp_rv1 = 1'b0;

  logic [15:0] mem [0:1023];
  logic [15:0] shadow [0:1023];
  logic [1023:0] sh_valid;
  logic        mem_init = 1'b1;

  always #5 i_clk = ~i_clk;

  z16_dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BURST(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0(i_req0), .i_addr0(i_addr0), .i_wen0(i_wen0), .i_wdata0(i_wdata0), .i_lock0(i_lock0),
    .o_gnt0(o_gnt0), .o_rvalid0(o_rvalid0), .o_rdata0(o_rdata0),
    .i_req1(i_req1), .i_addr1(i_addr1), .i_wen1(i_wen1), .i_wdata1(i_wdata1), .i_lock1(i_lock1),
    .o_gnt1(o_gnt1), .o_rvalid1(o_rvalid1), .o_rdata1(o_rdata1),
    .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  function automatic logic [15:0] pattern(input int unsigned idx);
    return 16'(idx * 37 + 32'h1A2B);
  endfunction

  // Synchronous memory: read data appears the cycle after a read command.
  always @(posedge i_clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pattern(i);
    end else if (o_mem_en) begin
      if (o_mem_wen) mem[o_mem_addr[10:1]] <= o_mem_wdata;
      else           i_mem_rdata <= mem[o_mem_addr[10:1]];
    end
  end

  function automatic logic [15:0] exp_rd(input logic [15:0] addr);
    return sh_valid[addr[10:1]] ? shadow[addr[10:1]] : pattern(int'(addr[10:1]));
  endfunction

  function automatic cmd_t mk(input logic bubble, input logic [15:0] addr, input logic wen,
                              input logic [15:0] wdata, input logic lock);
    cmd_t c;
    c.bubble = bubble; c.addr = addr; c.wen = wen; c.wdata = wdata; c.lock = lock;
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_heads();
    if (q0.size() > 0 && !q0[0].bubble) begin
      i_req0 = 1'b1; i_addr0 = q0[0].addr; i_wen0 = q0[0].wen;
      i_wdata0 = q0[0].wdata; i_lock0 = q0[0].lock;
    end else begin
      i_req0 = 1'b0; i_addr0 = '0; i_wen0 = 1'b0; i_wdata0 = '0; i_lock0 = 1'b0;
    end
    if (q1.size() > 0 && !q1[0].bubble) begin
      i_req1 = 1'b1; i_addr1 = q1[0].addr; i_wen1 = q1[0].wen;
      i_wdata1 = q1[0].wdata; i_lock1 = q1[0].lock;
    end else begin
      i_req1 = 1'b0; i_addr1 = '0; i_wen1 = 1'b0; i_wdata1 = '0; i_lock1 = 1'b0;
    end
  endtask

  task automatic accept(input cmd_t c, input int port);
    if (c.wen) begin
      shadow[c.addr[10:1]] = c.wdata;
      sh_valid[c.addr[10:1]] = 1'b1;
    end else if (port == 0) begin
      sb0.push_back(exp_rd(c.addr));
      exp_rv0 = 1'b1;
    end else begin
      sb1.push_back(exp_rd(c.addr));
      exp_rv1 = 1'b1;
    end
  endtask

  task automatic run_phase(input string name);
    int   cyc;
    int   exp;
    cmd_t c;
    cyc = 0;
    while ((q0.size() > 0 || q1.size() > 0 || exp_gnt.size() > 0 || exp_rv0 || exp_rv1) && cyc < 60) begin
      drive_heads();
      @(negedge i_clk);
      exp = (exp_gnt.size() > 0) ? exp_gnt.pop_front() : -1;
      check({name, "_gnt0"}, 32'(o_gnt0), 32'(exp == 0));
      check({name, "_gnt1"}, 32'(o_gnt1), 32'(exp == 1));
      check({name, "_mem_en"}, 32'(o_mem_en), 32'(exp >= 0));
      if (exp == 0 && q0.size() > 0) begin
        check({name, "_mem_addr0"}, 32'(o_mem_addr), 32'(q0[0].addr));
        check({name, "_mem_wen0"}, 32'(o_mem_wen), 32'(q0[0].wen));
        if (q0[0].wen) check({name, "_mem_wdata0"}, 32'(o_mem_wdata), 32'(q0[0].wdata));
      end
      if (exp == 1 && q1.size() > 0) begin
        check({name, "_mem_addr1"}, 32'(o_mem_addr), 32'(q1[0].addr));
        check({name, "_mem_wen1"}, 32'(o_mem_wen), 32'(q1[0].wen));
        if (q1[0].wen) check({name, "_mem_wdata1"}, 32'(o_mem_wdata), 32'(q1[0].wdata));
      end
      check({name, "_rvalid0"}, 32'(o_rvalid0), 32'(exp_rv0));
      check({name, "_rvalid1"}, 32'(o_rvalid1), 32'(exp_rv1));
      if (exp_rv0 && sb0.size() > 0) check({name, "_rdata0"}, 32'(o_rdata0), 32'(sb0.pop_front()));
      if (exp_rv1 && sb1.size() > 0) check({name, "_rdata1"}, 32'(o_rdata1), 32'(sb1.pop_front()));
      exp_rv0 = 1'b0;
      exp_rv1 = 1'b0;
      if (q0.size() > 0) begin
        if (q0[0].bubble) void'(q0.pop_front());
        else if (o_gnt0) begin c = q0.pop_front(); accept(c, 0); end
      end
      if (q1.size() > 0) begin
        if (q1[0].bubble) void'(q1.pop_front());
        else if (o_gnt1) begin c = q1.pop_front(); accept(c, 1); end
      end
      step();
      cyc++;
    end
    check({name, "_drained"}, 32'(q0.size() + q1.size() + exp_gnt.size() + sb0.size() + sb1.size()), 32'd0);
    q0.delete(); q1.delete(); exp_gnt.delete(); sb0.delete(); sb1.delete();
    exp_rv0 = 1'b0; exp_rv1 = 1'b0;
  endtask

  initial begin
    sh_valid = '0;
    i_rst = 1'b1;
    i_req0 = 1'b1; i_addr0 = 16'h0010; i_wen0 = 1'b1; i_wdata0 = 16'h1111; i_lock0 = 1'b0;
    i_req1 = 1'b1; i_addr1 = 16'h0020; i_wen1 = 1'b1; i_wdata1 = 16'h2222; i_lock1 = 1'b0;
    step();
    mem_init = 1'b0;
    step();
    @(negedge i_clk);
    check("rst_gnt0", 32'(o_gnt0), 32'd0);
    check("rst_gnt1", 32'(o_gnt1), 32'd0);
    check("rst_mem_en", 32'(o_mem_en), 32'd0);
    check("rst_mem_wen", 32'(o_mem_wen), 32'd0);
    check("rst_rvalid0", 32'(o_rvalid0), 32'd0);
    check("rst_rvalid1", 32'(o_rvalid1), 32'd0);
    step();
    i_rst = 1'b0;

    // Simultaneous reads right after reset: port 0 wins the first tie.
    q0.push_back(mk(0, 16'h0010, 0, '0, 0));
    q1.push_back(mk(0, 16'h0020, 0, '0, 0));
    exp_gnt = '{0, 1};
    run_phase("t1");

    // Continuous unlocked traffic alternates.
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(0, 16'(16'h0030 + 4 * i), 0, '0, 0));
      q1.push_back(mk(0, 16'(16'h0080 + 4 * i), 0, '0, 0));
      exp_gnt.push_back(0);
      exp_gnt.push_back(1);
    end
    run_phase("t2");

    // Twelve locked port-1 writes: burst capped at 8, port 0 slips in, port 1 resumes.
    q0.push_back(mk(1, '0, 0, '0, 0));
    q0.push_back(mk(0, 16'h0050, 0, '0, 0));
    for (int i = 0; i < 12; i++) begin
      q1.push_back(mk(0, 16'(16'h0100 + 2 * i), 1, 16'(16'hD000 + i), logic'(i != 11)));
    end
    for (int i = 0; i < 8; i++) exp_gnt.push_back(1);
    exp_gnt.push_back(0);
    for (int i = 0; i < 4; i++) exp_gnt.push_back(1);
    run_phase("t3");

    // Lock released by a request bubble at beat 3.
    q1.push_back(mk(0, 16'h0200, 1, 16'h1234, 1));
    q1.push_back(mk(0, 16'h0202, 1, 16'h5678, 1));
    q1.push_back(mk(1, '0, 0, '0, 0));
    q1.push_back(mk(0, 16'h0200, 0, '0, 0));
    q0.push_back(mk(1, '0, 0, '0, 0));
    q0.push_back(mk(0, 16'h0060, 0, '0, 0));
    exp_gnt = '{1, 1, -1, 0, 1};
    run_phase("t4");

    // Write from port 0, read back from port 1.
    q0.push_back(mk(0, 16'h0040, 1, 16'hBEEF, 0));
    q1.push_back(mk(1, '0, 0, '0, 0));
    q1.push_back(mk(0, 16'h0040, 0, '0, 0));
    exp_gnt = '{0, 1};
    run_phase("t5");
    check("t5_shadow_beef", 32'(exp_rd(16'h0040)), 32'h0000BEEF);

    // Reset mid-burst and in the cycle after a read grant.
    i_req1 = 1'b1; i_addr1 = 16'h0300; i_wen1 = 1'b1; i_wdata1 = 16'hAAAA; i_lock1 = 1'b1;
    @(negedge i_clk);
    check("t6_burst_gnt1", 32'(o_gnt1), 32'd1);
    step();
    i_addr1 = 16'h0302;
    i_req0 = 1'b1; i_addr0 = 16'h0010; i_wen0 = 1'b0; i_lock0 = 1'b0;
    @(negedge i_clk);
    check("t6_locked_gnt1", 32'(o_gnt1), 32'd1);
    check("t6_locked_gnt0", 32'(o_gnt0), 32'd0);
    step();
    i_rst = 1'b1;
    @(negedge i_clk);
    check("t6_rst_gnt0", 32'(o_gnt0), 32'd0);
    check("t6_rst_gnt1", 32'(o_gnt1), 32'd0);
    check("t6_rst_mem_en", 32'(o_mem_en), 32'd0);
    check("t6_rst_mem_wen", 32'(o_mem_wen), 32'd0);
    step();
    i_rst = 1'b0;
    i_addr1 = 16'h0020; i_wen1 = 1'b0; i_lock1 = 1'b0;
    @(negedge i_clk);
    check("t6_unlock_gnt0", 32'(o_gnt0), 32'd1);
    check("t6_unlock_gnt1", 32'(o_gnt1), 32'd0);
    step();
    i_rst = 1'b1; i_req0 = 1'b0; i_req1 = 1'b0;
    @(negedge i_clk);
    check("t6_rst_rvalid0", 32'(o_rvalid0), 32'd0);
    step();
    i_rst = 1'b0;
    @(negedge i_clk);
    check("t6_post_rvalid0", 32'(o_rvalid0), 32'd0);
    check("t6_post_rvalid1", 32'(o_rvalid1), 32'd0);
    step();
    i_req0 = 1'b1; i_req1 = 1'b1;
    @(negedge i_clk);
    check("t6_tie_gnt0", 32'(o_gnt0), 32'd1);
    check("t6_tie_gnt1", 32'(o_gnt1), 32'd0);
    step();
    i_req0 = 1'b0;
    @(negedge i_clk);
    check("t6_next_gnt1", 32'(o_gnt1), 32'd1);
    check("t6_rvalid0", 32'(o_rvalid0), 32'd1);
    check("t6_rdata0", 32'(o_rdata0), 32'(exp_rd(16'h0010)));
    step();
    i_req1 = 1'b0;
    @(negedge i_clk);
    check("t6_rvalid1", 32'(o_rvalid1), 32'd1);
    check("t6_rvalid0_clear", 32'(o_rvalid0), 32'd0);
    check("t6_rdata1", 32'(o_rdata1), 32'(exp_rd(16'h0020)));
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
